// File: rtl/fifo_channel.sv
// Single-clock FIFO carrying producer words to the consumer, with occupancy
// decodes and sticky overflow/underflow flags for dropped or phantom words.
module fifo_channel #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  clear,
  input  logic                  we,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  re,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AF_CNT    = (DEPTH_LOG2 + 1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  always_comb begin
    full        = (count == DEPTH_CNT);
    empty       = (count == '0);
    almost_full = (count >= AF_CNT);
    wr_ok       = we && !full;
    rd_ok       = re && !empty;
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (ce && !clear && wr_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (ce) begin
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        dout_valid <= 1'b0;
        overflow   <= 1'b0;
        underflow  <= 1'b0;
      end else begin
        dout_valid <= rd_ok;
        if (wr_ok)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_ok) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (we && full)
          overflow <= 1'b1;
        if (re && empty)
          underflow <= 1'b1;
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_channel.sv
// Directed bench for fifo_channel: a reference queue predicts every read,
// and expected words wait in a scoreboard until dout_valid shows them.
module tb_fifo_channel;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        clear = 1'b0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic        re = 1'b0;
  logic        full, almost_full, empty, dout_valid, overflow, underflow;
  logic [31:0] dout;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_dout = '0;
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  fifo_channel #(.WIDTH(32), .DEPTH_LOG2(4), .AF_LEVEL(12)) dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .clear(clear),
    .we(we), .din(din), .full(full), .almost_full(almost_full),
    .re(re), .dout(dout), .dout_valid(dout_valid), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] want;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 16));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(mq.size() >= 12));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    chk({tag, ".dout"}, dout, m_dout);
  endtask

  // One clock with the given inputs; the model decides acceptance from the
  // pre-edge occupancy exactly as the FIFO must.
  task automatic step(input string tag, input bit w, input logic [31:0] d,
                      input bit r, input bit c, input bit e);
    bit rd, wr;
    @(negedge clock);
    we = w; din = d; re = r; clear = c; ce = e;
    @(posedge clock);
    #1;
    if (e) begin
      if (c) begin
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_valid = 1'b0;
      end else begin
        rd = r && (mq.size() > 0);
        wr = w && (mq.size() < 16);
        if (r && !rd) m_unf = 1'b1;
        if (w && !wr) m_ovf = 1'b1;
        if (rd) begin
          m_dout = mq.pop_front();
          exp_q.push_back(m_dout);
        end
        if (wr) mq.push_back(d);
        m_valid = rd;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) chk({tag, ".phantom"}, 32'(dout_valid), 32'd0);
        else chk({tag, ".sb"}, dout, exp_q.pop_front());
      end
    end
    check_state(tag);
    we = 1'b0; re = 1'b0; clear = 1'b0; ce = 1'b1;
  endtask

  initial begin
    #3;
    check_state("reset");
    @(negedge clock);
    reset_n = 1'b1;
    ce = 1'b1;

    for (int i = 1; i <= 5; i++) step("wr5", 1, 32'(i), 0, 0, 1);
    for (int i = 0; i < 5; i++)  step("rd5", 0, '0, 1, 0, 1);
    step("idle1", 0, '0, 0, 0, 1);

    for (int i = 0; i < 16; i++) step("fill", 1, 32'hA0 + 32'(i), 0, 0, 1);
    step("ovf", 1, 32'hFF, 0, 0, 1);
    for (int i = 0; i < 16; i++) step("drain", 0, '0, 1, 0, 1);
    step("idle2", 0, '0, 0, 0, 1);

    for (int i = 0; i < 10; i++) step("pre_wr", 1, 32'h50 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 10; i++) step("pre_rd", 0, '0, 1, 0, 1);
    for (int i = 0; i < 12; i++) step("wrap_wr", 1, 32'h100 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 12; i++) step("wrap_rd", 0, '0, 1, 0, 1);

    for (int i = 0; i < 3; i++) step("sim_pre", 1, 32'h200 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 4; i++) step("sim_rw", 1, 32'h300 + 32'(i), 1, 0, 1);
    for (int i = 0; i < 3; i++) step("sim_drain", 0, '0, 1, 0, 1);
    step("empty_rw", 1, 32'h400, 1, 0, 1);

    for (int i = 0; i < 3; i++) step("ce_pre", 1, 32'h500 + 32'(i), 0, 0, 1);
    step("ce_off_w", 1, 32'hDEAD, 0, 0, 0);
    step("ce_off_r", 0, '0, 1, 0, 0);
    step("ce_off_c", 0, '0, 0, 1, 0);
    step("clear_w", 1, 32'hBEEF, 0, 1, 1);
    step("after_clr", 0, '0, 1, 0, 1);

    for (int i = 0; i < 8; i++) step("rst_pre", 1, 32'h600 + 32'(i), 0, 0, 1);
    step("rst_rd", 0, '0, 1, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    step("post_wr", 1, 32'h12345678, 0, 0, 1);
    step("post_rd", 0, '0, 1, 0, 1);
    step("post_idle", 0, '0, 0, 0, 1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
